// File: rtl/axi_rd_arbiter.sv
// Two-port AXI read arbiter: instruction fetch (port 0) and data load (port 1)
// share one AXI read master. Define ROUND_ROBIN_EN for round-robin tie-breaking.
//
// state | meaning
// IDLE  | no transaction; arbitrate and accept one AR request
// ADDR  | registered AR presented on master port until m_arready
// DATA  | R beats routed to the granted port until the m_rlast beat
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              s0_arvalid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  output logic              s0_arready,
  output logic              s0_rvalid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rlast,
  input  logic              s0_rready,

  input  logic              s1_arvalid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  output logic              s1_arready,
  output logic              s1_rvalid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rlast,
  input  logic              s1_rready,

  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [1:0]        m_arburst,
  output logic [2:0]        m_arsize,
  output logic [3:0]        m_arcache,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  output logic              m_rready,

  output logic              busy,
  output logic              grant,
  output logic              err_rlast
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_cnt_q;
  logic              err_q;

  logic              in_idle;
  logic              in_addr;
  logic              in_data;
  logic              req_any;
  logic              win;
  logic              beat;

  assign in_idle = (state_q == IDLE);
  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);
  assign req_any = s0_arvalid | s1_arvalid;

  // Winner index: a lone requester always wins; only a tie needs a policy.
`ifdef ROUND_ROBIN_EN
  always_comb begin
    win = s1_arvalid;
    if (s0_arvalid && s1_arvalid) win = ~last_grant_q;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;

  always_comb begin
    win = s1_arvalid;
  end
`endif

  assign s0_arready = in_idle & s0_arvalid & ~win;
  assign s1_arready = in_idle & s1_arvalid &  win;

  assign m_arvalid = in_addr;
  assign m_araddr  = in_addr ? addr_q : '0;
  assign m_arlen   = in_addr ? len_q  : '0;
  assign m_arburst = 2'b01;
  assign m_arsize  = (DATA_W == 64) ? 3'd3 : 3'd2;
  assign m_arcache = 4'b0011;

  // R channel is steered only while a burst is outstanding; the idle port sees zeros.
  assign m_rready  = in_data & (grant_q ? s1_rready : s0_rready);
  assign beat      = m_rvalid & m_rready;

  assign s0_rvalid = in_data & ~grant_q & m_rvalid;
  assign s0_rlast  = in_data & ~grant_q & m_rlast;
  assign s0_rdata  = (in_data & ~grant_q) ? m_rdata : '0;
  assign s1_rvalid = in_data &  grant_q & m_rvalid;
  assign s1_rlast  = in_data &  grant_q & m_rlast;
  assign s1_rdata  = (in_data &  grant_q) ? m_rdata : '0;

  assign busy      = ~in_idle;
  assign grant     = grant_q;
  assign err_rlast = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            addr_q       <= win ? s1_araddr : s0_araddr;
            len_q        <= win ? s1_arlen  : s0_arlen;
            grant_q      <= win;
            last_grant_q <= win;
            state_q      <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            beat_cnt_q <= '0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            // rlast must coincide exactly with the beat numbered arlen
            if (m_rlast != (beat_cnt_q == len_q)) err_q <= 1'b1;
            if (m_rlast) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized self-checking bench for axi_rd_arbiter against a transaction-level
// model (winner choice, beat routing, rlast/length consistency).
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk, rst_n;
  logic          s0_arvalid, s0_arready, s0_rvalid, s0_rlast, s0_rready;
  logic [AW-1:0] s0_araddr;
  logic [7:0]    s0_arlen;
  logic [DW-1:0] s0_rdata;
  logic          s1_arvalid, s1_arready, s1_rvalid, s1_rlast, s1_rready;
  logic [AW-1:0] s1_araddr;
  logic [7:0]    s1_arlen;
  logic [DW-1:0] s1_rdata;
  logic          m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [1:0]    m_arburst;
  logic [2:0]    m_arsize;
  logic [3:0]    m_arcache;
  logic [DW-1:0] m_rdata;
  logic          busy, grant, err_rlast;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arready(s0_arready),
    .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rlast(s0_rlast), .s0_rready(s0_rready),
    .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arready(s1_arready),
    .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rlast(s1_rlast), .s1_rready(s1_rready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
    .m_arsize(m_arsize), .m_arcache(m_arcache), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rready(m_rready),
    .busy(busy), .grant(grant), .err_rlast(err_rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: which port won last (ties alternate in round-robin) and sticky error.
  bit last_g  = 1'b1;
  bit err_exp = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit pick(input bit v0, input bit v1);
    if (v0 && v1) begin
`ifdef ROUND_ROBIN_EN
      return !last_g;
`else
      return 1'b1;
`endif
    end
    return v1;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_grant"},   grant, 0);
    check({tag, "_arvalid"}, m_arvalid, 0);
    check({tag, "_araddr"},  m_araddr, 0);
    check({tag, "_rready"},  m_rready, 0);
    check({tag, "_s0"},      {s0_arready, s0_rvalid, s0_rlast, s0_rdata}, 0);
    check({tag, "_s1"},      {s1_arready, s1_rvalid, s1_rlast, s1_rdata}, 0);
    check({tag, "_err"},     err_rlast, 0);
  endtask

  task automatic apply_reset();
    s0_arvalid = 0; s1_arvalid = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
    s0_rready = 0; s1_rready = 0;
    rst_n = 0;
    #1 check_quiet("reset");
    @(posedge clk); #1 rst_n = 1;
    last_g = 1'b1; err_exp = 1'b0;
  endtask

  // One transaction; arvalid/araddr/arlen of both ports must be set by the caller.
  // last_at < 0 means the slave places rlast correctly at beat arlen.
  task automatic run_burst(input int arwait, input int last_at);
    bit w, rr, done;
    logic [AW-1:0] a;
    logic [7:0] l;
    int lastidx, i, cyc;
    w = pick(s0_arvalid, s1_arvalid);
    a = w ? s1_araddr : s0_araddr;
    l = w ? s1_arlen : s0_arlen;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_err", err_rlast, err_exp);
    check("idle_m_arvalid", m_arvalid, 0);
    check("arready0", s0_arready, s0_arvalid && !w);
    check("arready1", s1_arready, s1_arvalid && w);
    @(posedge clk); #1;
    if (w) s1_arvalid = 0; else s0_arvalid = 0;
    last_g = w;
    for (int k = 0; k < arwait; k++) begin
      @(negedge clk);
      check("addr_arvalid", m_arvalid, 1);
      check("addr_araddr", m_araddr, a);
      check("addr_arlen", m_arlen, l);
      check("addr_grant", grant, w);
      check("addr_busy", busy, 1);
      check("addr_arready", {s0_arready, s1_arready}, 0);
      @(posedge clk); #1;
    end
    m_arready = 1;
    @(negedge clk);
    check("ar_arvalid", m_arvalid, 1);
    check("ar_araddr", m_araddr, a);
    check("ar_arlen", m_arlen, l);
    check("ar_const", {m_arburst, m_arsize, m_arcache}, {2'b01, 3'd2, 4'b0011});
    @(posedge clk); #1 m_arready = 0;
    lastidx = (last_at >= 0) ? last_at : int'(l);
    i = 0; cyc = 0; done = 0;
    while (!done && cyc < 200) begin
      m_rvalid = ($urandom_range(0, 3) != 0);
      m_rdata  = $urandom;
      m_rlast  = (i == lastidx);
      s0_rready = 1'($urandom_range(0, 1));
      s1_rready = 1'($urandom_range(0, 1));
      rr = w ? s1_rready : s0_rready;
      @(negedge clk);
      check("data_busy", busy, 1);
      check("m_rready", m_rready, rr);
      check("win_r", w ? {s1_rvalid, s1_rlast, s1_rdata} : {s0_rvalid, s0_rlast, s0_rdata},
            {m_rvalid, m_rlast, m_rdata});
      check("lose_r", w ? {s0_rvalid, s0_rlast, s0_rdata} : {s1_rvalid, s1_rlast, s1_rdata}, 0);
      check("data_arready", {s0_arready, s1_arready}, 0);
      if (m_rvalid && rr) begin
        if (m_rlast != (i == int'(l))) err_exp = 1'b1;
        if (m_rlast) done = 1;
        i++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_rvalid = 0; m_rlast = 0; s0_rready = 0; s1_rready = 0;
    check("burst_timeout", done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s0_araddr = 0; s0_arlen = 0; s1_araddr = 0; s1_arlen = 0; m_rdata = 0;
    apply_reset();

    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("noreq_busy", busy, 0);
      check("noreq_arvalid", m_arvalid, 0);
    end
    @(posedge clk); #1;

    // Single fetch
    s0_arvalid = 1; s0_araddr = 32'h100; s0_arlen = 0;
    run_burst(0, -1);

    // Collision: loser stays valid and is served next
    s0_arvalid = 1; s0_araddr = 32'h200;  s0_arlen = 1;
    s1_arvalid = 1; s1_araddr = 32'h3000; s1_arlen = 2;
    run_burst(0, -1);
    run_burst(1, -1);

    // Three ties after reset
    @(negedge clk);
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      s0_arvalid = 1; s0_araddr = 32'h400 + k * 16; s0_arlen = 8'(k);
      s1_arvalid = 1; s1_araddr = 32'h5000 + k * 16; s1_arlen = 8'(k + 1);
      @(negedge clk);
      check("tie_grant_idx", s1_arready, pick(1, 1));
      @(posedge clk); #1;
      apply_reset_free();
    end

    // Backpressure on AR and R
    s0_arvalid = 0; s1_arvalid = 1; s1_araddr = 32'h6000; s1_arlen = 3;
    run_burst(3, -1);

    // Randomized traffic with occasional misplaced rlast
    for (int n = 0; n < 30; n++) begin
      s0_arvalid = 1'($urandom_range(0, 1));
      s1_arvalid = 1'($urandom_range(0, 1));
      if (!s0_arvalid && !s1_arvalid) s0_arvalid = 1;
      s0_araddr = $urandom; s0_arlen = 8'($urandom_range(0, 3));
      s1_araddr = $urandom; s1_arlen = 8'($urandom_range(0, 3));
      run_burst($urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1);
    end

    // Early rlast, then clean bursts keep the sticky error
    s0_arvalid = 0; s1_arvalid = 1; s1_araddr = 32'h7000; s1_arlen = 3;
    run_burst(0, 1);
    check("err_model_set", err_exp, 1);
    s1_arvalid = 1; s1_araddr = 32'h7100; s1_arlen = 1;
    run_burst(0, -1);
    s0_arvalid = 1; s0_araddr = 32'h7200; s0_arlen = 0;
    run_burst(0, -1);
    @(negedge clk);
    check("err_sticky", err_rlast, 1);
    @(posedge clk); #1;

    // Reset during beat 1 of a 4-beat fetch
    s0_arvalid = 1; s0_araddr = 32'h8000; s0_arlen = 3;
    @(posedge clk); #1 s0_arvalid = 0; m_arready = 1;
    @(posedge clk); #1 m_arready = 0; m_rvalid = 1; s0_rready = 1; m_rdata = 32'hDEADBEEF;
    @(posedge clk); #1 m_rdata = 32'h12345678;
    @(negedge clk);
    check("mid_rvalid", s0_rvalid, 1);
    #1 rst_n = 0;
    #1 check_quiet("midrst");
    m_rvalid = 0; s0_rready = 0;
    @(posedge clk); #1 rst_n = 1;
    last_g = 1'b1; err_exp = 1'b0;

    s0_arvalid = 1; s0_araddr = 32'h9000; s0_arlen = 2;
    run_burst(0, -1);
    @(negedge clk);
    check("end_busy", busy, 0);
    check("end_err", err_rlast, err_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Completes the burst already accepted on the preceding edge of a tie test.
  task automatic apply_reset_free();
    bit w;
    w = pick(1, 1);
    if (w) s1_arvalid = 0; else s0_arvalid = 0;
    last_g = w;
    @(negedge clk);
    check("tie_grant", grant, w);
    check("tie_addr", m_araddr, w ? s1_araddr : s0_araddr);
    @(posedge clk); #1 m_arready = 1;
    @(posedge clk); #1 m_arready = 0;
    m_rvalid = 1; m_rlast = 1; s0_rready = 1; s1_rready = 1;
    if ((w ? s1_arlen : s0_arlen) != 0) err_exp = 1'b1;
    @(posedge clk); #1 m_rvalid = 0; m_rlast = 0; s0_rready = 0; s1_rready = 0;
    s0_arvalid = 0; s1_arvalid = 0;
    @(negedge clk);
    check("tie_idle", busy, 0);
    check("tie_err", err_rlast, err_exp);
    @(posedge clk); #1;
  endtask

endmodule
